// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size and state encodings, read-latency bounds, alignment helpers.
package lsu_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    size_e       size;
    logic        uns;
  } lsu_req_t;

  // Encoding 11 behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : size_e'(s);
  endfunction

  function automatic logic misaligned(
    input size_e      s,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (s)
      SZ_HALF: m = lo[0];
      SZ_WORD: m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] align_lo(
    input size_e      s,
    input logic [1:0] lo
  );
    logic [1:0] r;
    r = lo;
    unique case (s)
      SZ_HALF: r = {lo[1], 1'b0};
      SZ_WORD: r = 2'b00;
      default: r = lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; lane chosen by the low address bits.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b          = rword[{lo, 3'b000} +: 8];
    h          = rword[{lo[1], 4'b0000} +: 16];
    load_data  = rword;
    store_word = wdata;
    unique case (size)
      SZ_BYTE: begin
        load_data  = {{24{~uns & b[7]}}, b};
        store_word = rword;
        store_word[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~uns & h[15]}}, h};
        store_word = rword;
        store_word[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rword;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic        req_we_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wr_data_out,
  input  logic [31:0] mem_rd_data_in,
  output logic        mem_we_out
);

  state_e      state;
  lsu_req_t    req;
  logic [1:0]  cnt;
  logic [31:0] rword;
  logic        err;

  size_e       in_size;
  logic [31:0] in_addr;
  logic        trap;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign in_size = norm_size(req_size_in);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = misaligned(in_size, req_addr_in[1:0]);
  assign in_addr = req_addr_in;
`else
  assign trap    = 1'b0;
  assign in_addr = {req_addr_in[31:2],
                    align_lo(in_size, req_addr_in[1:0])};
`endif

  assign req_ready_out = (state == S_IDLE) && !rst_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      req   <= '0;
      cnt   <= '0;
      rword <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_in) begin
            req <= '{addr:  in_addr,
                     wdata: req_wdata_in,
                     we:    req_we_in,
                     size:  in_size,
                     uns:   req_unsigned_in};
            err <= trap;
            cnt <= 2'(RD_LATENCY);
            if (trap)
              state <= S_RESP;
            else if (req_we_in && in_size == SZ_WORD)
              state <= S_WRITE;
            else
              state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            rword <= mem_rd_data_in;
            state <= req.we ? S_WRITE : S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  lsu_byte_lane u_lane (
    .size       (req.size),
    .uns        (req.uns),
    .lo         (req.addr[1:0]),
    .rword      (rword),
    .wdata      (req.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    mem_addr_out    = '0;
    mem_we_out      = 1'b0;
    mem_wr_data_out = '0;
    resp_valid_out  = 1'b0;
    resp_rdata_out  = '0;
    resp_err_out    = 1'b0;
    unique case (state)
      S_RD_WAIT: mem_addr_out = {req.addr[31:2], 2'b00};
      S_WRITE: begin
        mem_addr_out    = {req.addr[31:2], 2'b00};
        mem_we_out      = 1'b1;
        mem_wr_data_out = store_word;
      end
      S_RESP: begin
        resp_valid_out = 1'b1;
        resp_err_out   = err;
        if (!req.we && !err)
          resp_rdata_out = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench: LSU at RD_LATENCY 1 and 3 against a reference model.
// Each instance has its own word memory with latency-gated read data.
module tb_load_store_unit;

  localparam int LAT [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;

  logic        rdy [2];
  logic        rv [2];
  logic        err [2];
  logic        mwe [2];
  logic [31:0] rdat [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];

  logic [31:0] mem [2][256];
  logic [31:0] ref_mem [256];
  logic [31:0] prev [2];
  int          stab [2];
  int          run [2];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LATENCY(1)) u1 (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(valid), .req_ready_out(rdy[0]),
    .req_addr_in(addr), .req_wdata_in(wdata),
    .req_we_in(we), .req_size_in(size),
    .req_unsigned_in(uns),
    .resp_valid_out(rv[0]), .resp_rdata_out(rdat[0]),
    .resp_err_out(err[0]),
    .mem_addr_out(maddr[0]), .mem_wr_data_out(mwd[0]),
    .mem_rd_data_in(mrd[0]), .mem_we_out(mwe[0])
  );

  load_store_unit #(.RD_LATENCY(3)) u3 (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(valid), .req_ready_out(rdy[1]),
    .req_addr_in(addr), .req_wdata_in(wdata),
    .req_we_in(we), .req_size_in(size),
    .req_unsigned_in(uns),
    .resp_valid_out(rv[1]), .resp_rdata_out(rdat[1]),
    .resp_err_out(err[1]),
    .mem_addr_out(maddr[1]), .mem_wr_data_out(mwd[1]),
    .mem_rd_data_in(mrd[1]), .mem_we_out(mwe[1])
  );

  // Read data is only valid once the address has been stable LAT cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      run[i] = (maddr[i] == prev[i]) ? stab[i] + 1 : 0;
      mrd[i] = (!mwe[i] && run[i] >= LAT[i] - 1)
             ? mem[i][maddr[i][9:2]] : 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev[i] <= maddr[i];
      stab[i] <= (run[i] > 100) ? 100 : run[i];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a[9:2]] = v;
    mem[0][a[9:2]] = v;
    mem[1][a[9:2]] = v;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word,
                                           input logic [31:0] a,
                                           input int nb,
                                           input logic u);
    logic [31:0] v;
    logic [31:0] m;
    int sh;
    if (nb == 4) return word;
    sh = int'(a[1:0]) * 8;
    m = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> sh) & m;
    if (!u && v[nb*8-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old,
                                            input logic [31:0] d,
                                            input logic [31:0] a,
                                            input int nb);
    logic [31:0] m;
    int sh;
    if (nb == 4) return d;
    sh = int'(a[1:0]) * 8;
    m = ((nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~m) | ((d << sh) & m);
  endfunction

  task automatic scramble();
    addr  = $urandom;
    wdata = $urandom;
    we    = 1'($urandom);
    size  = 2'($urandom);
    uns   = 1'($urandom);
  endtask

  task automatic xact(input string nm,
                      input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [1:0] s,
                      input logic u);
    int nb;
    logic mis, trap;
    logic [31:0] ea, ew, exp_rd, merged;
    int exp_lat [2];
    int got_lat [2];
    int nwe [2];
    int rdc [2];
    int extra [2];
    logic [31:0] got_rd [2];
    logic [31:0] got_wa [2];
    logic [31:0] got_wd [2];
    logic [31:0] rsp_a [2];
    logic got_err [2];
    logic bad_rdy [2];
    logic bad_q [2];
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
    ea   = a;
`else
    trap = 1'b0;
    ea   = (nb == 1) ? a : (nb == 2) ? (a & ~32'd1) : (a & ~32'd3);
`endif
    ew     = {ea[31:2], 2'b00};
    exp_rd = (w || trap) ? 32'd0 : ref_load(ref_mem[ea[9:2]], ea, nb, u);
    merged = ref_merge(ref_mem[ea[9:2]], d, ea, nb);
    for (int i = 0; i < 2; i++) begin
      exp_lat[i] = trap ? 1 : !w ? LAT[i] + 1 : (nb == 4) ? 2 : LAT[i] + 2;
      got_lat[i] = 0; nwe[i] = 0; rdc[i] = 0; extra[i] = 0;
      got_rd[i] = '0; got_wa[i] = '0; got_wd[i] = '0; rsp_a[i] = '0;
      got_err[i] = 1'b0; bad_rdy[i] = 1'b0; bad_q[i] = 1'b0;
    end
    @(negedge clk);
    check({nm, "/ready0"}, 32'(rdy[0]), 32'd1);
    check({nm, "/ready1"}, 32'(rdy[1]), 32'd1);
    valid = 1'b1; we = w; addr = a; wdata = d; size = s; uns = u;
    @(posedge clk);
    #1;
    valid = 1'b0;
    scramble();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && got_lat[i] != 0) extra[i]++;
        if (rv[i] && got_lat[i] == 0) begin
          got_lat[i] = c;
          got_rd[i]  = rdat[i];
          got_err[i] = err[i];
          rsp_a[i]   = maddr[i];
        end else if (rdat[i] != 0) begin
          bad_q[i] = 1'b1;
        end
        if (got_lat[i] == 0) begin
          if (rdy[i]) bad_rdy[i] = 1'b1;
          if (mwe[i]) begin
            nwe[i]++;
            got_wa[i] = maddr[i];
            got_wd[i] = mwd[i];
            mem[i][maddr[i][9:2]] = mwd[i];
          end else if (maddr[i] == ew) begin
            rdc[i]++;
          end
        end else if (mwe[i]) begin
          nwe[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      string t;
      t = $sformatf("%s/L%0d", nm, LAT[i]);
      check({t, " lat"}, 32'(got_lat[i]), 32'(exp_lat[i]));
      check({t, " rdata"}, got_rd[i], exp_rd);
      check({t, " err"}, 32'(got_err[i]), 32'(trap));
      check({t, " we_cnt"}, 32'(nwe[i]), (w && !trap) ? 32'd1 : 32'd0);
      if (w && !trap) begin
        check({t, " we_addr"}, got_wa[i], ew);
        check({t, " we_data"}, got_wd[i], merged);
      end
      check({t, " rd_cycles"}, 32'(rdc[i]),
            (trap || (w && nb == 4)) ? 32'd0 : 32'(LAT[i]));
      check({t, " ready_low"}, 32'(bad_rdy[i]), 32'd0);
      check({t, " rdata_quiet"}, 32'(bad_q[i]), 32'd0);
      check({t, " resp_addr0"}, rsp_a[i], 32'd0);
      check({t, " one_resp"}, 32'(extra[i]), 32'd0);
    end
    if (w && !trap) ref_mem[ea[9:2]] = merged;
  endtask

  task automatic reset_mid_store();
    int nwe, nrv;
    nwe = 0; nrv = 0;
    @(negedge clk);
    valid = 1'b1; we = 1'b1; addr = 32'h104; wdata = $urandom;
    size = 2'd0; uns = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b0;
    scramble();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst/L%0d ready", LAT[i]), 32'(rdy[i]), 32'd0);
      check($sformatf("rst/L%0d addr", LAT[i]), maddr[i], 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mwe[i]) nwe++;
        if (rv[i]) nrv++;
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mwe[i]) nwe++;
        if (rv[i]) nrv++;
        if (c == 0)
          check($sformatf("rst/L%0d ready_after", LAT[i]),
                32'(rdy[i]), 32'd1);
      end
    end
    check("rst we_pulses", 32'(nwe), 32'd0);
    check("rst resp_pulses", 32'(nrv), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) set_word(32'(k * 4), $urandom);
    #2;
    check("reset ready0", 32'(rdy[0]), 32'd0);
    check("reset ready1", 32'(rdy[1]), 32'd0);
    check("reset resp0", {rv[0], err[0], mwe[0]}, 32'd0);
    check("reset bus0", maddr[0] | mwd[0] | rdat[0], 32'd0);
    check("reset bus1", maddr[1] | mwd[1] | rdat[1], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset ready0", 32'(rdy[0]), 32'd1);
    check("post_reset ready1", 32'(rdy[1]), 32'd1);

    xact("wst100", 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    set_word(32'h80, 32'h1122_3344);
    xact("lb83", 1'b0, 32'h83, 32'h0, 2'd0, 1'b0);
    set_word(32'h80, 32'h1122_33F4);
    xact("lb80", 1'b0, 32'h80, 32'h0, 2'd0, 1'b0);
    xact("lbu80", 1'b0, 32'h80, 32'h0, 2'd0, 1'b1);
    set_word(32'h100, 32'h1122_3344);
    xact("sh102", 1'b1, 32'h102, 32'h0000_ABCD, 2'd1, 1'b0);
    xact("lw100", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    xact("lw102", 1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
    xact("lh103", 1'b0, 32'h103, 32'h0, 2'd1, 1'b0);
    xact("sz3", 1'b1, 32'h108, 32'h1234_5678, 2'd3, 1'b0);
    reset_mid_store();
    xact("lb104", 1'b0, 32'h104, 32'h0, 2'd0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      xact($sformatf("rnd%0d", n), 1'($urandom),
           32'h100 + 32'($urandom_range(0, 767)), $urandom,
           2'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning memory read latency in cycles (legal 1..3).
REQ-002 SHALL have clk_in  input  1  clock; all state on rising edge.
REQ-003 SHALL have rst_in  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have req_valid_in  input  1  core request valid.
REQ-005 SHALL have req_ready_out  output  1  unit accepts a request this cycle.
REQ-006 SHALL have req_addr_in  input  32  byte address.
REQ-007 SHALL have req_wdata_in  input  32  store data, right-aligned.
REQ-008 SHALL have req_we_in  input  1  1=store, 0=load.
REQ-009 SHALL have req_size_in  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 SHALL have req_unsigned_in  input  1  zero-extend loads when 1.
REQ-011 SHALL have resp_valid_out  output  1  one-cycle completion pulse.
REQ-012 SHALL have resp_rdata_out  output  32  extended load data.
REQ-013 SHALL have resp_err_out  output  1  misaligned request flag.
REQ-014 SHALL have mem_addr_out  output  32  word address to memory controller, bits[1:0]=00.
REQ-015 SHALL have mem_wr_data_out  output  32  full write word.
REQ-016 SHALL have mem_rd_data_in  input  32  read word, valid RD_LATENCY cycles after address with mem_we_out=0.
REQ-017 SHALL have mem_we_out  output  1  write strobe, one cycle per store.

Function
REQ-018 SHALL implement states IDLE, RD_WAIT, WRITE, RESP; req_ready_out=1 only in IDLE.
REQ-019 SHALL capture addr/wdata/we/size/unsigned on the edge where req_valid_in && req_ready_out; inputs ignored otherwise.
REQ-020 SHALL go IDLE->RD_WAIT for loads and for byte/half stores; IDLE->WRITE for word stores.
REQ-021 SHALL hold mem_addr_out stable with mem_we_out=0 for exactly RD_LATENCY cycles in RD_WAIT (down-counter), sampling mem_rd_data_in on the last.
REQ-022 SHALL exit RD_WAIT to RESP for loads, to WRITE for sub-word stores (read-modify-write).
REQ-023 SHALL in WRITE assert mem_we_out for one cycle with merged word: target byte lanes from req_wdata_in[7:0]/[15:0], other lanes from the sampled read word; then go to RESP.
REQ-024 SHALL in RESP assert resp_valid_out for one cycle, then return to IDLE; no back-to-back acceptance in RESP.
REQ-025 SHALL extract load lane by addr[1:0] (byte) or addr[1] (half), sign-extend unless req_unsigned_in; word returns unmodified.
REQ-026 SHALL hold resp_rdata_out at 0 for stores and outside RESP.
REQ-027 Latency: word store accepted at edge N -> mem_we_out cycle N+1, resp_valid_out cycle N+2; loads resp at N+RD_LATENCY+1; sub-word stores at N+RD_LATENCY+2.
REQ-028 SHALL drive mem_we_out=0 and mem_addr_out=0 in IDLE and RESP.

Reset
REQ-029 SHALL on rst_in asynchronously enter IDLE, clear counter and captured request, drive all outputs 0 except req_ready_out, which deasserts while rst_in=1 and is 1 from the first cycle after release.
REQ-030 SHALL abandon any in-flight access on reset mid-operation with no mem_we_out pulse and no resp_valid_out.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, send half at addr[0]=1 or word at addr[1:0]!=0 directly IDLE->RESP with resp_err_out=1, no memory access.
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, tie resp_err_out=0 and force low address bits to size alignment before access.

Structure
REQ-033 SHALL place size encoding enum, state enum, and RD_LATENCY bounds in shared package lsu_pkg.
REQ-034 SHALL put lane extract/sign-extend and store merge in combinational sub-module lsu_byte_lane.

Verification
REQ-035 Word store addr 0x100 data 0xDEADBEEF -> one mem_we_out at 0x100 data 0xDEADBEEF, resp_valid_out 2 cycles after accept.
REQ-036 Memory 0x80 holds 0x11223344; signed byte load 0x83 -> 0x00000011; signed byte load 0x80 with word 0x112233F4 -> 0xFFFFFFF4; unsigned -> 0x000000F4.
REQ-037 Half store 0xABCD to 0x102 over 0x11223344 -> read then write 0xABCD3344 at 0x100.
REQ-038 RD_LATENCY=3 load -> mem_addr_out held 3 cycles, resp_valid_out 4 cycles after accept; req_ready_out low throughout.
REQ-039 rst_in asserted during RD_WAIT of a byte store -> no mem_we_out, no resp_valid_out, IDLE after release.
REQ-040 Word load at 0x102: with LSU_MISALIGN_TRAP_EN -> resp_err_out=1, no memory access; without -> reads 0x100, resp_err_out=0.
